ifetch_queue: RTL

Instruction fetch controller and queue, placed directly downstream of the PC register. It issues fetch requests at the current `PC` to an instruction memory over a variable-latency request/grant/response interface, and buffers returned words with their addresses in a 4-entry FIFO. It presents them to decode with a valid/ready handshake. It drives the PC register's advance enable and discards in-flight and queued fetches on a control-flow redirect.

---
 rtl/ifetch_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch controller with a DEPTH-entry queue between instruction memory and decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue #(
  parameter int width = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] PC,
  input  logic             flush,
  output logic             pc_advance,
  output logic             imem_req,
  output logic [width-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [width-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [width-1:0] Instr,
  output logic [width-1:0] InstrPC,
  output logic [width-1:0] PCPlus4
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WAIT_DROP
  } state_t;

  state_t state, state_next;

  logic [width-1:0] addr_q;
  logic [width-1:0] mem_data [DEPTH];
  logic [width-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic q_empty, q_full, resp_keep, push, pop;

  assign q_empty    = (count == '0);
  assign q_full     = (count == CNT_W'(DEPTH));
  assign imem_req   = rst_n && (state == S_IDLE) && !flush && !q_full;
  assign pc_advance = imem_req & imem_gnt;
  assign imem_addr  = imem_req ? PC : '0;
  assign resp_keep  = (state == S_WAIT) && imem_rvalid && !flush;
  assign pop        = !q_empty && instr_ready;

`ifdef IFQ_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = resp_keep && q_empty;
  // A bypassed word that decode takes immediately never occupies a slot
  assign push       = resp_keep && !(bypass_hit && instr_ready);
`else
  assign push       = resp_keep;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (pc_advance) addr_q <= PC;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (pc_advance) state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)  state_next = S_IDLE;
        else if (flush)   state_next = S_WAIT_DROP;
      end
      S_WAIT_DROP: if (imem_rvalid) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_addr[wr_ptr] <= addr_q;
    end
  end

  // A redirect empties the queue and overrides any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    instr_valid = 1'b0;
    Instr       = '0;
    InstrPC     = '0;
    PCPlus4     = '0;
    if (!q_empty) begin
      instr_valid = 1'b1;
      Instr       = mem_data[rd_ptr];
      InstrPC     = mem_addr[rd_ptr];
      PCPlus4     = mem_addr[rd_ptr] + width'(4);
    end
`ifdef IFQ_BYPASS_EN
    else if (bypass_hit) begin
      instr_valid = 1'b1;
      Instr       = imem_rdata;
      InstrPC     = addr_q;
      PCPlus4     = addr_q + width'(4);
    end
`endif
  end

endmodule
